// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// The readback/verify pass is built only when CCFF_READBACK_EN is defined.
package ccff_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CHAIN_LEN = 48;

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_LOAD   = 2'd1,
        E_VERIFY = 2'd2,
        E_DONE   = 2'd3
    } ccff_state_e;

    localparam logic [1:0] ST_IDLE   = E_IDLE;
    localparam logic [1:0] ST_LOAD   = E_LOAD;
    localparam logic [1:0] ST_VERIFY = E_VERIFY;
    localparam logic [1:0] ST_DONE   = E_DONE;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the chain loader.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader_serializer.sv
// MSB-first PISO for one bitstream word; emits at most one bit per cycle and
// takes the next word while the last held bit leaves, so streams have no bubble.
module ccff_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              i_clear,
    input  logic              i_emit_en,
    input  logic              i_accept_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_bit_vld,
    output logic              o_bit
);
    localparam int FILL_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_sr;
    logic [FILL_W-1:0] r_fill;
    logic              w_held;
    logic              w_take;

    assign w_held    = i_emit_en && (r_fill != '0);
    assign o_ready   = i_accept_en && i_emit_en &&
                       ((r_fill == '0) || (r_fill == FILL_W'(1)));
    assign w_take    = o_ready && i_valid;
    assign o_bit_vld = w_held || w_take;
    // A word taken into an empty register supplies its MSB straight away.
    assign o_bit     = w_held ? r_sr[DATA_W-1] : i_data[DATA_W-1];

    always_ff @(posedge prog_clk) begin
        if (prog_reset || i_clear) begin
            r_sr   <= '0;
            r_fill <= '0;
        end else if (w_take) begin
            if (w_held) begin
                r_sr   <= i_data;
                r_fill <= FILL_W'(DATA_W);
            end else begin
                r_sr   <= i_data << 1;
                r_fill <= FILL_W'(DATA_W - 1);
            end
        end else if (w_held) begin
            r_sr   <= r_sr << 1;
            r_fill <= r_fill - FILL_W'(1);
        end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// Drives a configuration flip-flop chain from a word stream, MSB first.
// Define CCFF_READBACK_EN to add a recirculating popcount verify pass.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               prog_clk,
    input  logic               prog_reset,
    input  logic               start,
    ccff_chain_loader_if.slave cfg,
    output logic               ccff_head,
    output logic               ccff_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   bit_count,
    output logic               cfg_error
);
    localparam int NWORDS = ceil_div(CHAIN_LEN, DATA_W);
    localparam int WCNT_W = $clog2(NWORDS + 1);

    logic [1:0]        r_state;
    logic              r_head;
    logic              r_shift_en;
    logic [CNT_W-1:0]  r_bit_count;
    logic [CNT_W-1:0]  r_issued;
    logic [WCNT_W-1:0] r_words;
    logic              w_start;
    logic              w_in_load;
    logic              w_emit_en;
    logic              w_accept_en;
    logic              w_last_shift;
    logic              w_ready;
    logic              w_bit_vld;
    logic              w_bit;

    assign w_start      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_load    = (r_state == ST_LOAD);
    // r_issued runs one cycle ahead of r_bit_count; it stops emission at the chain length.
    assign w_emit_en    = w_in_load && (r_issued != CNT_W'(CHAIN_LEN));
    assign w_accept_en  = w_in_load && (r_words != WCNT_W'(NWORDS));
    assign w_last_shift = w_in_load && r_shift_en && (r_bit_count == CNT_W'(CHAIN_LEN - 1));

    ccff_serializer #(.DATA_W(DATA_W)) u_ser (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .i_clear     (w_start),
        .i_emit_en   (w_emit_en),
        .i_accept_en (w_accept_en),
        .i_data      (cfg.cfg_data),
        .i_valid     (cfg.cfg_valid),
        .o_ready     (w_ready),
        .o_bit_vld   (w_bit_vld),
        .o_bit       (w_bit)
    );

    assign cfg.cfg_ready = w_ready;
    assign ccff_shift_en = r_shift_en;
    assign busy          = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign done          = (r_state == ST_DONE);
    assign bit_count     = r_bit_count;

`ifdef CCFF_READBACK_EN
    logic [CNT_W-1:0] r_ones_wr;
    logic [CNT_W-1:0] r_ones_rd;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_cfg_error;
    logic             w_vlast;

    assign w_vlast   = (r_state == ST_VERIFY) && (r_vcnt == CNT_W'(CHAIN_LEN - 1));
    // The tail must feed the head combinationally, otherwise the loop is one bit too long.
    assign ccff_head = (r_state == ST_VERIFY) ? ccff_tail : r_head;
    assign cfg_error = r_cfg_error;

    always_ff @(posedge prog_clk) begin
        if (prog_reset || w_start) begin
            r_ones_wr   <= '0;
            r_ones_rd   <= '0;
            r_vcnt      <= '0;
            r_cfg_error <= 1'b0;
        end else if (w_in_load) begin
            if (r_shift_en && r_head)
                r_ones_wr <= r_ones_wr + CNT_W'(1);
        end else if (r_state == ST_VERIFY) begin
            r_ones_rd <= r_ones_rd + CNT_W'(ccff_tail);
            r_vcnt    <= r_vcnt + CNT_W'(1);
            if (w_vlast)
                r_cfg_error <= ((r_ones_rd + CNT_W'(ccff_tail)) != r_ones_wr);
        end
    end
`else
    logic w_unused_tail;

    assign w_unused_tail = ccff_tail;
    assign ccff_head     = r_head;
    assign cfg_error     = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state     <= ST_IDLE;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_bit_count <= '0;
            r_issued    <= '0;
            r_words     <= '0;
        end else if (w_start) begin
            r_state     <= ST_LOAD;
            r_shift_en  <= 1'b0;
            r_bit_count <= '0;
            r_issued    <= '0;
            r_words     <= '0;
        end else if (w_in_load) begin
            r_shift_en <= w_bit_vld;
            if (w_bit_vld) begin
                r_head   <= w_bit;
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_ready && cfg.cfg_valid)
                r_words <= r_words + WCNT_W'(1);
            if (r_shift_en)
                r_bit_count <= r_bit_count + CNT_W'(1);
            if (w_last_shift) begin
`ifdef CCFF_READBACK_EN
                r_state    <= ST_VERIFY;
                r_shift_en <= 1'b1;
`else
                r_state    <= ST_DONE;
`endif
            end
        end
`ifdef CCFF_READBACK_EN
        else if (w_vlast) begin
            r_state    <= ST_DONE;
            r_shift_en <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: two loaders (48-bit and 20-bit chains) with behavioural chain models.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
`ifdef CCFF_READBACK_EN
    localparam int VMUL = 2;
`else
    localparam int VMUL = 1;
`endif
    localparam logic [47:0] EXP_A = 48'hA53CFF00817E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, a_start, b_start, stuck;
    logic       a_head, a_sen, a_tail, a_busy, a_done, a_err;
    logic       b_head, b_sen, b_tail, b_busy, b_done, b_err;
    logic [5:0] a_cnt;
    logic [4:0] b_cnt;
    logic [47:0] chain_a = '0;
    logic [19:0] chain_b = '0;

    ccff_chain_loader_if #(.DATA_W(8)) ifa ();
    ccff_chain_loader_if #(.DATA_W(8)) ifb ();

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(48)) dut_a (
        .prog_clk(clk), .prog_reset(rst), .start(a_start), .cfg(ifa),
        .ccff_head(a_head), .ccff_shift_en(a_sen), .ccff_tail(a_tail),
        .busy(a_busy), .done(a_done), .bit_count(a_cnt), .cfg_error(a_err));

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(20)) dut_b (
        .prog_clk(clk), .prog_reset(rst), .start(b_start), .cfg(ifb),
        .ccff_head(b_head), .ccff_shift_en(b_sen), .ccff_tail(b_tail),
        .busy(b_busy), .done(b_done), .bit_count(b_cnt), .cfg_error(b_err));

    // Head enters bit 0, first bit ends at the MSB (the tail); bit 20 of A can be stuck at 1.
    always @(posedge clk) begin
        if (a_sen) chain_a <= {chain_a[46:0], a_head} | (stuck ? (48'h1 << 20) : 48'h0);
        if (b_sen) chain_b <= {chain_b[18:0], b_head};
    end
    assign a_tail = chain_a[47];
    assign b_tail = chain_b[19];

    int   checks = 0, errors = 0, cyc = 0;
    int   sh[2], gap[2], headmove[2], first[2], last[2], pushed[2], acc[2], t_acc[2];
    logic prev[2];
    logic q0[$];
    logic q1[$];
    logic exp_bit;
    logic [7:0] words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    always @(negedge clk) begin
        if (a_sen) begin
            if (sh[0] < 48) begin
                if (q0.size() == 0) fail("a_head_underflow");
                else begin exp_bit = q0.pop_front(); check("a_head_bit", 64'(a_head), 64'(exp_bit)); end
            end
            if (sh[0] == 0) first[0] = cyc;
            last[0] = cyc;
            sh[0]++;
        end else if (sh[0] > 0 && a_busy) begin
            gap[0]++;
            if (a_head !== prev[0]) headmove[0]++;
        end
        prev[0] = a_head;
    end

    always @(negedge clk) begin
        if (b_sen) begin
            if (sh[1] < 20) begin
                if (q1.size() == 0) fail("b_head_underflow");
                else begin exp_bit = q1.pop_front(); check("b_head_bit", 64'(b_head), 64'(exp_bit)); end
            end
            if (sh[1] == 0) first[1] = cyc;
            last[1] = cyc;
            sh[1]++;
        end else if (sh[1] > 0 && b_busy) begin
            gap[1]++;
            if (b_head !== prev[1]) headmove[1]++;
        end
        prev[1] = b_head;
    end

    function automatic logic rdy(input int s);
        return (s != 0) ? ifb.cfg_ready : ifa.cfg_ready;
    endfunction

    function automatic logic dn(input int s);
        return (s != 0) ? b_done : a_done;
    endfunction

    task automatic set_word(input int s, input logic v, input logic [7:0] w);
        if (s == 0) begin ifa.cfg_valid = v; ifa.cfg_data = w; end
        else        begin ifb.cfg_valid = v; ifb.cfg_data = w; end
    endtask

    task automatic begin_load(input int s);
        sh[s] = 0; gap[s] = 0; headmove[s] = 0; pushed[s] = 0; acc[s] = 0; t_acc[s] = 0;
        if (s == 0) q0.delete(); else q1.delete();
        @(posedge clk); #1;
        if (s == 0) a_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
    endtask

    task automatic send(input int s, input logic [7:0] w);
        int t = 0;
        int lim = (s != 0) ? 20 : 48;
        set_word(s, 1'b1, w);
        @(negedge clk);
        while (!rdy(s) && t < 300) begin @(negedge clk); t++; end
        if (!rdy(s)) fail("send_timeout");
        else begin
            for (int i = 7; i >= 0; i--)
                if (pushed[s] < lim) begin
                    if (s == 0) q0.push_back(w[i]); else q1.push_back(w[i]);
                    pushed[s]++;
                end
            if (acc[s] == 0) t_acc[s] = cyc;
            acc[s]++;
            $display("dut%0d word %0d = %02h accepted at cycle %0d", s, acc[s], w, cyc);
        end
        @(posedge clk); #1;
        set_word(s, 1'b0, w);
    endtask

    task automatic offer_extra(input int s, input string name);
        int seen = 0;
        set_word(s, 1'b1, 8'h55);
        repeat (8) begin @(negedge clk); if (rdy(s)) seen++; end
        @(posedge clk); #1;
        set_word(s, 1'b0, 8'h55);
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic wait_done(input int s);
        int t = 0;
        @(negedge clk);
        while (!dn(s) && t < 600) begin @(negedge clk); t++; end
        if (!dn(s)) fail("done_timeout");
    endtask

    task automatic full_a(input string tag);
        begin_load(0);
        for (int i = 0; i < 6; i++) send(0, words[i]);
        wait_done(0);
        check({tag, "_latency"}, 64'(first[0]), 64'(t_acc[0] + 1));
        check({tag, "_shifts"}, 64'(sh[0]), 64'(48 * VMUL));
        check({tag, "_span"}, 64'(last[0] - first[0] + 1), 64'(48 * VMUL));
        check({tag, "_chain"}, 64'(chain_a), 64'(EXP_A));
        check({tag, "_bit_count"}, 64'(a_cnt), 64'd48);
        check({tag, "_done"}, 64'(a_done), 64'd1);
        check({tag, "_busy"}, 64'(a_busy), 64'd0);
        check({tag, "_cfg_error"}, 64'(a_err), 64'd0);
        check({tag, "_queue_empty"}, 64'(q0.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; stuck = 1'b0;
        set_word(0, 1'b0, 8'h00);
        set_word(1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_shift_en", 64'(a_sen), 64'd0);
        check("rst_ready", 64'(ifa.cfg_ready), 64'd0);
        check("rst_head", 64'(a_head), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_bit_count", 64'(a_cnt), 64'd0);
        check("rst_cfg_error", 64'(a_err), 64'd0);

        full_a("t1");

        // Stall: valid stays low through the fill==1 cycle plus three empty-register cycles.
        begin_load(0);
        send(0, words[0]);
        send(0, words[1]);
        begin
            int t = 0;
            @(negedge clk);
            while (!ifa.cfg_ready && t < 50) begin @(negedge clk); t++; end
            if (!ifa.cfg_ready) fail("t2_stall_ready_timeout");
        end
        @(posedge clk); #1;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        @(negedge clk);
        check("t2_start_ignored_count", 64'(a_cnt), 64'd16);
        check("t2_start_ignored_busy", 64'(a_busy), 64'd1);
        @(posedge clk); #1;
        for (int i = 2; i < 6; i++) send(0, words[i]);
        offer_extra(0, "t2_extra_word_rejected");
        wait_done(0);
        check("t2_shifts", 64'(sh[0]), 64'(48 * VMUL));
        check("t2_stall_cycles", 64'(gap[0]), 64'd3);
        check("t2_head_frozen", 64'(headmove[0]), 64'd0);
        check("t2_chain", 64'(chain_a), 64'(EXP_A));
        check("t2_bit_count", 64'(a_cnt), 64'd48);
        check("t2_accepts", 64'(acc[0]), 64'd6);

        begin_load(1);
        send(1, 8'hFF);
        send(1, 8'hFF);
        send(1, 8'hF0);
        @(negedge clk);
        check("t3_ready_drop", 64'(ifb.cfg_ready), 64'd0);
        offer_extra(1, "t3_extra_word_rejected");
        wait_done(1);
        check("t3_shifts", 64'(sh[1]), 64'(20 * VMUL));
        check("t3_chain", 64'(chain_b), 64'hFFFFF);
        check("t3_bit_count", 64'(b_cnt), 64'd20);
        check("t3_done", 64'(b_done), 64'd1);
        check("t3_cfg_error", 64'(b_err), 64'd0);

        begin_load(0);
        for (int i = 0; i < 3; i++) send(0, words[i]);
        begin
            int t = 0;
            while (sh[0] < 17 && t < 50) begin @(negedge clk); #1; t++; end
            if (sh[0] < 17) fail("t4_shift17_timeout");
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t4_reset_shift_en", 64'(a_sen), 64'd0);
        check("t4_reset_bit_count", 64'(a_cnt), 64'd0);
        check("t4_reset_busy", 64'(a_busy), 64'd0);
        check("t4_reset_ready", 64'(ifa.cfg_ready), 64'd0);
        full_a("t4_reload");

`ifdef CCFF_READBACK_EN
        stuck = 1'b1;
        begin_load(0);
        for (int i = 0; i < 6; i++) send(0, words[i]);
        wait_done(0);
        check("t5_stuck_cfg_error", 64'(a_err), 64'd1);
        check("t5_stuck_shifts", 64'(sh[0]), 64'd96);
        stuck = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
